slap_spr_dma: RTL and testbench
===============================

# slap_spr_dma

Sprite-RAM copy engine between the CPU-side dual-port sprite RAM (read-only port B here) and the double-banked sprite line-fetch buffer. On each vblank rising edge it copies LEN words from source RAM into the current write bank of the buffer. It then flips banks, so the sprite renderer always reads a complete, stable frame of sprite attributes.

## Interface
- AW, 11: source address width; the buffer address is AW+1 bits.
- DW, 8: data width.
- LEN, 2048: words per copy, 1..2^AW.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high
- cen  in  1  clock enable shared with the source RAM; the engine advances only on clk edges with cen=1
- vblank  in  1  video vblank level; sampled on cen edges
- src_addr  out  AW  source RAM port-B address
- src_q  in  DW  source RAM port-B data, registered by the RAM on cen edges
- dst_addr  out  AW+1  buffer address = {wr_bank, index}
- dst_data  out  DW  buffer write data
- dst_nWE  out  1  buffer write strobe, active low, exactly one clk wide per word
- busy  out  1  copy in progress
- done  out  1  one-clk pulse at copy completion
- disp_bank  out  1  bank the renderer must read (= ~wr_bank)

## Operation
- Reset values: src_addr=0, dst_addr=0, dst_data=0, dst_nWE=1, busy=0, done=0, wr_bank=0, disp_bank=1, vblank_d=0, state=IDLE.
- vblank_d <= vblank on every cen edge. A trigger is cen & vblank & ~vblank_d.
- IDLE: src_addr=0, dst_nWE=1.
  - On trigger: go to PRIME, busy<=1, rd_cnt<=0.
- PRIME, one cen edge: src_addr<=1 and go to COPY. The RAM captures ram[0] on this same edge.
- COPY, per cen edge:
  - dst_addr<={wr_bank, wr_idx}, dst_data<=src_q, dst_nWE<=0, wr_idx++.
  - src_addr<=src_addr+1, wrapping mod 2^AW; src_addr values beyond LEN-1 are don't-care reads.
  - After the write with wr_idx=LEN-1: go to FLIP.
- FLIP, next clk regardless of cen:
  - dst_nWE=1, done<=1 for one clk, busy<=0, wr_bank<=~wr_bank (disp_bank follows).
  - Then return to IDLE.
- dst_nWE returns to 1 on the clk following any clk in which it was 0. With cen low, no new strobe is issued and all other registers hold.
- vblank edges while busy are ignored, not queued.
- A vblank edge in the same cen cycle as FLIP is also ignored, because vblank_d is already 1.
- Reset mid-copy:
  - Abort immediately; all outputs take their reset values on that edge.
  - wr_bank returns to 0. The partially written bank is never displayed, because disp_bank=1.

## Timing
- With cen held 1, trigger at edge T (state→PRIME):
  - Word i is strobed with dst_nWE=0 during the clk after edge T+2+i, i=0..LEN-1.
  - done=1 during the clk after edge T+LEN+2.
  - busy is high for the clks following edges T..T+LEN+1.
- Read latency is one cen edge: dst_data for index i equals ram[i] as returned on src_q. The buffer samples dst_* on the next clk edge.
- With cen gated, each stage waits for its cen edge. FLIP and strobe release are clk-timed, not cen-timed.
- disp_bank changes on the same edge that done rises.

## Test plan
- Reset then idle: hold vblank=0 for 100 clks → dst_nWE=1, busy=0, disp_bank=1, src_addr=0 throughout.
- Full copy, cen=1, LEN=2048, src RAM preloaded ram[i]=i[7:0]^8'h5A:
  - Expect exactly 2048 single-clk strobes to addresses {0, i} with data i^8'h5A.
  - done pulses once, at T+2050.
  - disp_bank becomes 0.
- cen=1 every 3rd clk, LEN=16:
  - Expect 16 writes with correct data.
  - Each dst_nWE low pulse is exactly 1 clk.
  - Nothing is written while cen=0.
- Two consecutive frames:
  - The second copy targets addresses {1, i}; disp_bank ends at 1.
  - A vblank toggle (0→1→0→1) during the first copy produces no extra copy.
- Reset asserted after 5 words:
  - Next clk: dst_nWE=1, busy=0, wr_bank=0, disp_bank=1.
  - The following vblank edge restarts the copy from index 0.
- LEN=1: exactly one strobe to {0, 0}, done at T+3, src_addr back to 0 in IDLE.

Source files
------------

// File: rtl/slap_spr_dma.sv
// Sprite-RAM copy engine: on each vblank rising edge copies LEN words from the
// source RAM into the write bank of a double-banked line buffer, then flips banks.
module slap_spr_dma #(
  parameter int AW  = 11,
  parameter int DW  = 8,
  parameter int LEN = 2048
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cen,
  input  logic          vblank,
  output logic [AW-1:0] src_addr,
  input  logic [DW-1:0] src_q,
  output logic [AW:0]   dst_addr,
  output logic [DW-1:0] dst_data,
  output logic          dst_nWE,
  output logic          busy,
  output logic          done,
  output logic          disp_bank,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {IDLE, PRIME, COPY, FLIP} state_t;

  localparam logic [AW-1:0] LAST = AW'(LEN - 1);

  state_t        state;
  logic          wr_bank;
  logic          vblank_d;
  logic [AW-1:0] wr_idx;
  logic          trigger;

  assign trigger   = cen & vblank & ~vblank_d;
  assign disp_bank = ~wr_bank;
  assign state_dbg = state;

  // Buffer write protocol: dst_addr/dst_data are valid while dst_nWE=0, which
  // lasts exactly one clk per word; the buffer samples them on the next clk edge.
  // There is no back-pressure: the buffer must accept every strobed word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      src_addr <= '0;
      dst_addr <= '0;
      dst_data <= '0;
      dst_nWE  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_bank  <= 1'b0;
      vblank_d <= 1'b0;
      wr_idx   <= '0;
    end else begin
      dst_nWE <= 1'b1;
      done    <= 1'b0;
      if (cen) vblank_d <= vblank;
      case (state)
        IDLE: begin
          src_addr <= '0;
          if (trigger) begin
            state  <= PRIME;
            busy   <= 1'b1;
            wr_idx <= '0;
          end
        end
        PRIME: begin
          // The RAM registers ram[0] on this same cen edge.
          if (cen) begin
            src_addr <= AW'(1);
            state    <= COPY;
          end
        end
        COPY: begin
          if (cen) begin
            dst_addr <= {wr_bank, wr_idx};
            dst_data <= src_q;
            dst_nWE  <= 1'b0;
            wr_idx   <= wr_idx + 1'b1;
            src_addr <= src_addr + 1'b1;
            if (wr_idx == LAST) state <= FLIP;
          end
        end
        FLIP: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          wr_bank  <= ~wr_bank;
          src_addr <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slap_spr_dma.sv
// Directed bench for slap_spr_dma: three instances (LEN 2048, 16, 1) share clk and
// reset; sel routes the stimulus to one instance and its outputs to the m_* view.
module tb_slap_spr_dma;

  logic clk, reset, vb, ce;
  int   sel;
  int   chk_cnt, pass_cnt;

  logic [10:0] sa_a, sa_b, sa_c;
  logic [7:0]  q_a, q_b, q_c, dd_a, dd_b, dd_c;
  logic [11:0] da_a, da_b, da_c;
  logic        nwe_a, nwe_b, nwe_c, busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c, disp_a, disp_b, disp_c;
  logic [1:0]  st_a, st_b, st_c;
  logic        cen_a, cen_b, cen_c, vb_a, vb_b, vb_c;

  logic [10:0] m_sa;
  logic [11:0] m_da;
  logic [7:0]  m_dd;
  logic        m_nwe, m_busy, m_done, m_disp;
  logic [1:0]  m_st;

  logic [19:0] exp_q[$];

  function automatic logic [7:0] rv(input logic [10:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cen_a = (sel == 0) ? ce : 1'b1;
  assign cen_b = (sel == 1) ? ce : 1'b1;
  assign cen_c = (sel == 2) ? ce : 1'b1;
  assign vb_a  = (sel == 0) ? vb : 1'b0;
  assign vb_b  = (sel == 1) ? vb : 1'b0;
  assign vb_c  = (sel == 2) ? vb : 1'b0;

  // Source RAM port B models: registered read on cen edges
  always @(posedge clk) if (cen_a) q_a <= rv(sa_a);
  always @(posedge clk) if (cen_b) q_b <= rv(sa_b);
  always @(posedge clk) if (cen_c) q_c <= rv(sa_c);

  slap_spr_dma #(.AW(11), .DW(8), .LEN(2048)) dut_a (
    .clk(clk), .reset(reset), .cen(cen_a), .vblank(vb_a), .src_addr(sa_a), .src_q(q_a),
    .dst_addr(da_a), .dst_data(dd_a), .dst_nWE(nwe_a), .busy(busy_a), .done(done_a),
    .disp_bank(disp_a), .state_dbg(st_a));
  slap_spr_dma #(.AW(11), .DW(8), .LEN(16)) dut_b (
    .clk(clk), .reset(reset), .cen(cen_b), .vblank(vb_b), .src_addr(sa_b), .src_q(q_b),
    .dst_addr(da_b), .dst_data(dd_b), .dst_nWE(nwe_b), .busy(busy_b), .done(done_b),
    .disp_bank(disp_b), .state_dbg(st_b));
  slap_spr_dma #(.AW(11), .DW(8), .LEN(1)) dut_c (
    .clk(clk), .reset(reset), .cen(cen_c), .vblank(vb_c), .src_addr(sa_c), .src_q(q_c),
    .dst_addr(da_c), .dst_data(dd_c), .dst_nWE(nwe_c), .busy(busy_c), .done(done_c),
    .disp_bank(disp_c), .state_dbg(st_c));

  always_comb begin
    m_sa = sa_a; m_da = da_a; m_dd = dd_a; m_nwe = nwe_a;
    m_busy = busy_a; m_done = done_a; m_disp = disp_a; m_st = st_a;
    if (sel == 1) begin
      m_sa = sa_b; m_da = da_b; m_dd = dd_b; m_nwe = nwe_b;
      m_busy = busy_b; m_done = done_b; m_disp = disp_b; m_st = st_b;
    end else if (sel == 2) begin
      m_sa = sa_c; m_da = da_c; m_dd = dd_c; m_nwe = nwe_c;
      m_busy = busy_c; m_done = done_c; m_disp = disp_c; m_st = st_c;
    end
  end

  // Driver tasks
  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; vb = 1'b0; ce = 1'b1; sel = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      chk_cnt++;
      if ({m_nwe, m_busy, m_done, m_disp, m_sa} !== {4'b1001, 11'd0}) begin
        $display("FAIL reset_idle k=%0d: got %h exp %h", k, {m_nwe, m_busy, m_done, m_disp, m_sa}, {4'b1001, 11'd0});
      end else pass_cnt++;
    end
    chk_cnt++;
    if ({disp_b, disp_c, st_a} !== 4'b1100) begin
      $display("FAIL reset_others: got %b exp %b", {disp_b, disp_c, st_a}, 4'b1100);
    end else pass_cnt++;
  endtask

  task automatic test_full_copy();
    int L = 2048;
    logic [3:0]  e_ctl;
    logic [10:0] e_sa, idx;
    sel = 0; ce = 1'b1; vb = 1'b1;
    for (int k = 1; k <= L + 4; k++) begin
      @(negedge clk);
      e_ctl = {~(k >= 3 && k <= L + 2), (k <= L + 2), (k == L + 3), ~(k >= L + 3)};
      e_sa  = (k >= 2 && k <= L + 2) ? 11'(k - 1) : 11'd0;
      chk_cnt++;
      if ({m_nwe, m_busy, m_done, m_disp, m_sa} !== {e_ctl, e_sa}) begin
        $display("FAIL full_ctl k=%0d: got %h exp %h", k, {m_nwe, m_busy, m_done, m_disp, m_sa}, {e_ctl, e_sa});
      end else pass_cnt++;
      if (k >= 3 && k <= L + 2) begin
        idx = 11'(k - 3);
        chk_cnt++;
        if ({m_da, m_dd} !== {1'b0, idx, rv(idx)}) begin
          $display("FAIL full_word k=%0d: got %h exp %h", k, {m_da, m_dd}, {1'b0, idx, rv(idx)});
        end else pass_cnt++;
      end
    end
    vb = 1'b0;
  endtask

  task automatic test_cen_gated();
    int strobes = 0, dones = 0;
    logic ce_edge = 1'b1, prev_nwe = 1'b1;
    logic [19:0] e;
    sel = 1; exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, 11'(i), rv(11'(i))});
    vb = 1'b1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge clk);
      if (m_nwe === 1'b0) begin
        strobes++;
        chk_cnt++;
        if ({ce_edge, prev_nwe} !== 2'b11) begin
          $display("FAIL gated_strobe cyc=%0d: got cen,prev_nwe=%b exp 11", cyc, {ce_edge, prev_nwe});
        end else pass_cnt++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hFFFFF;
        chk_cnt++;
        if ({m_da, m_dd} !== e) begin
          $display("FAIL gated_word cyc=%0d: got %h exp %h", cyc, {m_da, m_dd}, e);
        end else pass_cnt++;
      end
      if (m_done === 1'b1) dones++;
      prev_nwe = m_nwe;
      ce = (cyc % 3 == 0);
      ce_edge = ce;
    end
    chk_cnt++;
    if ({8'(strobes), 8'(dones), 8'(exp_q.size()), m_disp} !== {8'd16, 8'd1, 8'd0, 1'b0}) begin
      $display("FAIL gated_totals: got writes=%0d dones=%0d left=%0d disp=%b exp 16 1 0 0",
               strobes, dones, exp_q.size(), m_disp);
    end else pass_cnt++;
    ce = 1'b1; vb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_two_frames();
    int L = 16;
    logic [3:0]  e_ctl;
    logic [10:0] idx;
    logic        f_b;
    sel = 1; ce = 1'b1; vb = 1'b0;
    pulse_reset();
    for (int f = 0; f < 2; f++) begin
      f_b = 1'(f);
      vb = 1'b1;
      for (int k = 1; k <= L + 8; k++) begin
        @(negedge clk);
        e_ctl = {~(k >= 3 && k <= L + 2), (k <= L + 2), (k == L + 3), (k >= L + 3) ? f_b : ~f_b};
        chk_cnt++;
        if ({m_nwe, m_busy, m_done, m_disp} !== e_ctl) begin
          $display("FAIL frames_ctl f=%0d k=%0d: got %b exp %b", f, k, {m_nwe, m_busy, m_done, m_disp}, e_ctl);
        end else pass_cnt++;
        if (k >= 3 && k <= L + 2) begin
          idx = 11'(k - 3);
          chk_cnt++;
          if ({m_da, m_dd} !== {f_b, idx, rv(idx)}) begin
            $display("FAIL frames_word f=%0d k=%0d: got %h exp %h", f, k, {m_da, m_dd}, {f_b, idx, rv(idx)});
          end else pass_cnt++;
        end
        if (f == 0 && k == 5) vb = 1'b0;
        if (f == 0 && k == 7) vb = 1'b1;
      end
      vb = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int L = 16;
    sel = 1; ce = 1'b1; vb = 1'b1;
    repeat (L + 5) @(negedge clk);
    chk_cnt++;
    if (m_disp !== 1'b0) begin
      $display("FAIL mid_pre_bank: got disp=%b exp 0", m_disp);
    end else pass_cnt++;
    vb = 1'b0;
    @(negedge clk);
    vb = 1'b1;
    repeat (7) @(negedge clk);
    chk_cnt++;
    if ({m_nwe, m_da, m_dd} !== {1'b0, 12'h804, rv(11'd4)}) begin
      $display("FAIL mid_5th_word: got %h exp %h", {m_nwe, m_da, m_dd}, {1'b0, 12'h804, rv(11'd4)});
    end else pass_cnt++;
    vb = 1'b0;
    pulse_reset();
    chk_cnt++;
    if ({m_nwe, m_busy, m_done, m_disp, m_sa, m_da, m_dd, m_st} !== {4'b1001, 11'd0, 12'd0, 8'd0, 2'd0}) begin
      $display("FAIL mid_reset: got %h exp %h", {m_nwe, m_busy, m_done, m_disp, m_sa, m_da, m_dd, m_st},
               {4'b1001, 11'd0, 12'd0, 8'd0, 2'd0});
    end else pass_cnt++;
    @(negedge clk);
    vb = 1'b1;
    for (int k = 1; k <= L + 4; k++) begin
      @(negedge clk);
      if (k == 3) begin
        chk_cnt++;
        if ({m_nwe, m_da, m_dd} !== {1'b0, 12'h000, 8'h5A}) begin
          $display("FAIL mid_restart_word0: got %h exp %h", {m_nwe, m_da, m_dd}, {1'b0, 12'h000, 8'h5A});
        end else pass_cnt++;
      end
      if (k == L + 3) begin
        chk_cnt++;
        if ({m_done, m_disp} !== 2'b10) begin
          $display("FAIL mid_restart_done: got %b exp 10", {m_done, m_disp});
        end else pass_cnt++;
      end
    end
    vb = 1'b0;
  endtask

  task automatic test_len1();
    logic [3:0]  e_ctl;
    logic [10:0] e_sa;
    sel = 2; ce = 1'b1; vb = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      e_ctl = {(k != 3), (k <= 3), (k == 4), (k < 4)};
      e_sa  = (k == 2) ? 11'd1 : (k == 3) ? 11'd2 : 11'd0;
      chk_cnt++;
      if ({m_nwe, m_busy, m_done, m_disp, m_sa} !== {e_ctl, e_sa}) begin
        $display("FAIL len1_ctl k=%0d: got %h exp %h", k, {m_nwe, m_busy, m_done, m_disp, m_sa}, {e_ctl, e_sa});
      end else pass_cnt++;
      if (k == 3) begin
        chk_cnt++;
        if ({m_da, m_dd} !== {12'h000, 8'h5A}) begin
          $display("FAIL len1_word: got %h exp %h", {m_da, m_dd}, {12'h000, 8'h5A});
        end else pass_cnt++;
      end
    end
    chk_cnt++;
    if (m_st !== 2'd0) begin
      $display("FAIL len1_idle_state: got %0d exp 0", m_st);
    end else pass_cnt++;
    vb = 1'b0;
  endtask

  initial begin
    chk_cnt = 0; pass_cnt = 0;
    test_reset();
    test_full_copy();
    test_cen_gated();
    test_two_frames();
    test_reset_mid();
    test_len1();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
